debounce_scan_ctrl: RTL and testbench
=====================================

// Module: debounce_scan_ctrl
// PURPOSE
//  Time-multiplexes one 8-sample debounce filter over N_CH raw push-button inputs.
//  A prescaled sample tick starts each scan. The scan FSM walks the channels, one
//  per clock, and updates each channel's sample history and stable level.
//  Every debounced press or release becomes an event in a small FIFO, drained by
//  the consumer logic over a valid/ready handshake.
//  Sits between the board buttons and the control FSMs. Replaces per-button
//  filter instances.
// PARAMETERS
//  N_CH      4     number of button channels (1..16)
//  DEPTH     8     consecutive equal samples needed to change stable level (2..16)
//  PRESCALE  1000  clk cycles per sample tick; must be >= N_CH+2 (elaboration error otherwise)
//  FIFO_D    4     event FIFO depth, power of two
// PORTS
//  clk        in   1                clock, all logic on rising edge
//  rst_n      in   1                asynchronous active-low reset
//  btn_in     in   N_CH             raw, asynchronous button levels
//  level_out  out  N_CH             debounced stable level per channel
//  ev_valid   out  1                event available at FIFO head
//  ev_ch      out  $clog2(N_CH)|1   channel of head event
//  ev_level   out  1                1 = press (0->1), 0 = release (1->0)
//  ev_ready   in   1                consumer accepts head event when ev_valid&ev_ready
//  overflow   out  1                sticky: an event was dropped on a full FIFO
//  clr_ovf    in   1                synchronous clear of overflow
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): prescaler=0, FSM=IDLE, all histories=0,
//    level_out=0, FIFO empty, ev_valid=0, ev_ch=0, ev_level=0, overflow=0.
//  - btn_in passes a 2-flop synchronizer, per bit, before any use. The synchronizer also resets to 0.
//  - Prescaler counts 0..PRESCALE-1 and wraps. The tick is a 1-cycle pulse on the wrap, cycle T.
//  - FSM IDLE: on tick -> SCAN with idx=0.
//  - FSM SCAN: in cycle T+1+c it processes channel c:
//      hist[c] <= {hist[c][DEPTH-2:0], sync[c]}.
//      Evaluate the shifted value, new sample included.
//      If all ones and level=0 -> level<=1, push press event.
//      If all zeros and level=1 -> level<=0, push release event.
//      Otherwise hold level, no event.
//      After idx=N_CH-1 -> IDLE. A tick cannot occur during SCAN, guaranteed by the PRESCALE rule.
//  - level_out[c] updates on the edge that ends cycle T+1+c.
//  - An event pushed at the end of cycle T+1+c reaches the FIFO head. If the FIFO was empty,
//    ev_valid=1 in cycle T+2+c.
//  - At most one push per cycle. Events are ordered by channel index within a scan, and by scan order across scans.
//  - FIFO full and push with no pop: event dropped, level_out still updates, overflow<=1.
//  - FIFO full and push with pop in the same cycle: both occur, no drop.
//  - Empty FIFO: ev_ready is ignored. ev_ch and ev_level hold their last values.
//    ev_ch/ev_level stay stable while ev_valid&~ev_ready.
//  - overflow set and clr_ovf in the same cycle: set wins.
//  - rst_n asserted mid-scan: immediate return to reset state. The scan is abandoned.
//    The first scan after release starts at the next prescaler wrap.
//  - Effective debounce time is DEPTH*PRESCALE clks, plus up to PRESCALE+2 of sampling and synchronizer delay.
// STRUCTURE
//  - Shared package/include debounce_pkg: EV_PRESS=1'b1, EV_RELEASE=1'b0, the FSM state encoding
//    {IDLE, SCAN}, and a function clog2.
//  - Sub-module debounce_event_fifo: synchronous FIFO, width $clog2(N_CH)+1,
//    depth FIFO_D, push/full/pop/empty.
//  - Top holds the prescaler, synchronizer, history array, level register and scan FSM.
//    The all-ones/all-zeros evaluation is a single shared combinational path indexed by idx.
// TESTING  (bench: N_CH=4, DEPTH=8, PRESCALE=16, FIFO_D=4)
//  1. btn_in[2]=1 held from reset release.
//     -> Exactly one event {ch=2, level=1}, arriving on the 8th or 9th scan.
//     -> level_out=4'b0100. No further events for 20 more scans.
//  2. btn_in[0] toggles every 20 clks for 400 clks, then is held 0.
//     -> No events; level_out[0]=0 throughout.
//  3. Press btn[1] until debounced, then release.
//     -> Event {1,1}, then event {1,0} about 8 scans later. level_out[1] returns to 0.
//  4. ev_ready=0. Press all 4 buttons, then release all 4.
//     -> 4 press events in order ch0..ch3, FIFO full.
//     -> The 4 releases are dropped and overflow=1. level_out=0.
//     -> With ev_ready=1, exactly 4 events drain. clr_ovf pulse -> overflow=0.
//  5. FIFO full, ev_ready=1 in the cycle a new event pushes.
//     -> No drop, overflow stays 0, FIFO count stays 4.
//  6. rst_n pulsed low mid-SCAN with level_out=4'b1111.
//     -> level_out=0, ev_valid=0, overflow=0 immediately.
//     -> With buttons still held, press events re-emerge after DEPTH scans.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the time-multiplexed button debouncer.
//   EV_PRESS / EV_RELEASE : event level encoding (1 = press, 0 = release)
//   scan_state_t          : scan FSM state encoding
//   clog2                 : ceil(log2(v)) usable in constant expressions
package debounce_pkg;

    localparam logic EV_PRESS   = 1'b1;
    localparam logic EV_RELEASE = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_event_fifo.sv
// Small synchronous FIFO holding debounce events {channel, level}.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; ignored when full unless pop is also set
//   full       : FIFO holds D entries
//   pop        : read request; ignored when empty
//   dout       : head entry; while empty it holds the last entry popped
//   empty      : FIFO holds no entries
module debounce_event_fifo
    import debounce_pkg::*;
#(
    parameter int W = 3,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = (clog2(D) < 1) ? 1 : clog2(D);
    localparam int CW = clog2(D + 1);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  last;
    logic          wr_en, rd_en;

    assign full  = (count == CW'(D));
    assign empty = (count == '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= (rd_ptr == AW'(D - 1)) ? '0 : rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debounce filter for N_CH push buttons with an event FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_in     : raw asynchronous button levels
//   level_out  : debounced stable level per channel
//   ev_valid   : event available at FIFO head
//   ev_ch      : channel of head event
//   ev_level   : 1 = press, 0 = release
//   ev_ready   : consumer takes head event when ev_valid & ev_ready
//   overflow   : sticky, an event was dropped on a full FIFO
//   clr_ovf    : synchronous clear of overflow (a same-cycle drop wins)
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEPTH    = 8,
    parameter int PRESCALE = 1000,
    parameter int FIFO_D   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [N_CH-1:0]                           btn_in,
    output logic [N_CH-1:0]                           level_out,
    output logic                                      ev_valid,
    output logic [((N_CH > 1) ? clog2(N_CH) : 1)-1:0] ev_ch,
    output logic                                      ev_level,
    input  logic                                      ev_ready,
    output logic                                      overflow,
    input  logic                                      clr_ovf
);

    localparam int CH_W = (N_CH > 1) ? clog2(N_CH) : 1;
    localparam int PS_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    // A scan needs N_CH cycles plus the tick cycle before the next tick can land.
    generate
        if (PRESCALE < N_CH + 2) begin : g_bad_prescale
            $error("debounce_scan_ctrl: PRESCALE must be >= N_CH+2");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("debounce_scan_ctrl: DEPTH must be >= 2");
        end
    endgenerate

    logic [N_CH-1:0]             sync1, sync2;
    logic [PS_W-1:0]             ps_cnt;
    logic                        tick;
    scan_state_t                 state, state_nxt;
    logic [CH_W-1:0]             idx, idx_nxt;
    logic [N_CH-1:0][DEPTH-1:0]  hist;
    logic [N_CH-1:0]             level;
    logic [DEPTH-1:0]            shifted;
    logic                        proc, all_one, all_zero, push, push_level;
    logic                        full, empty, pop;
    logic [CH_W:0]               head;

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    // Synchronizer and sample prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            ps_cnt <= '0;
        end else begin
            sync1  <= btn_in;
            sync2  <= sync1;
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
        end
    end

    // Scan FSM: one channel per clock after each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (idx == LAST_CH) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Shared evaluation path: the history of the channel under scan with the
    // new sample already shifted in decides the level change.
    always_comb begin
        proc       = (state == SCAN);
        shifted    = {hist[idx][DEPTH-2:0], sync2[idx]};
        all_one    = &shifted;
        all_zero   = ~|shifted;
        push       = proc && ((all_one && !level[idx]) || (all_zero && level[idx]));
        push_level = all_one ? EV_PRESS : EV_RELEASE;
    end

    // Level follows the filter even when the event itself is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            level <= '0;
        end else if (proc) begin
            hist[idx] <= shifted;
            if (push) level[idx] <= push_level;
        end
    end

    assign pop = ev_valid && ev_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    debounce_event_fifo #(
        .W (CH_W + 1),
        .D (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({idx, push_level}),
        .full  (full),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );

    assign ev_valid  = !empty;
    assign ev_ch     = head[CH_W:1];
    assign ev_level  = head[0];
    assign level_out = level;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl (N_CH=4, DEPTH=8, PRESCALE=16, FIFO_D=4).
// The reference model tracks, per channel, the length of the current run of
// equal samples; a run reaching DEPTH that disagrees with the stable level
// flips it and produces an event into a bounded queue.
module tb_debounce_scan_ctrl;

    localparam int N_CH  = 4;
    localparam int DEPTH = 8;
    localparam int P     = 16;
    localparam int FD    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = '0;
    logic [3:0] level_out;
    logic       ev_valid;
    logic [1:0] ev_ch;
    logic       ev_level;
    logic       ev_ready = 1'b0;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    debounce_scan_ctrl #(
        .N_CH(N_CH), .DEPTH(DEPTH), .PRESCALE(P), .FIFO_D(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level_out(level_out),
        .ev_valid(ev_valid), .ev_ch(ev_ch), .ev_level(ev_level),
        .ev_ready(ev_ready), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;

    // Reference model state
    int         k;          // cycles since reset release
    logic [3:0] b_d1, b_d2; // button value one and two cycles back
    logic [3:0] m_level;
    logic [3:0] last_s;
    int         run [N_CH];
    logic [2:0] q [$];
    logic [2:0] m_last;
    logic       m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        k = 0; b_d1 = '0; b_d2 = '0; m_level = '0; last_s = '0;
        for (int c = 0; c < N_CH; c++) run[c] = DEPTH;
        q.delete(); m_last = '0; m_ovf = 1'b0;
    endfunction

    // Channel whose sample is taken in the current cycle, or -1.
    function automatic int m_chan();
        if (k >= P && (k % P) < N_CH) return k % P;
        return -1;
    endfunction

    // Whether the current cycle produces an event (used to time ev_ready).
    function automatic bit push_now();
        int c, r;
        logic s;
        c = m_chan();
        if (c < 0) return 1'b0;
        s = b_d2[c];
        r = (s == last_s[c]) ? run[c] + 1 : 1;
        return (r >= DEPTH) && (s != m_level[c]);
    endfunction

    // One clock cycle: compare outputs, then advance the model.
    task automatic step();
        int c;
        logic s, pop, have_ev, drop;
        logic [1:0] cc;
        logic [2:0] ev;
        @(negedge clk);
        chk("level", level_out, m_level);
        chk("valid", ev_valid, q.size() != 0);
        chk("head", {ev_ch, ev_level}, (q.size() != 0) ? q[0] : m_last);
        chk("ovf", overflow, m_ovf);
        if (ev_valid && ev_ready) n_pop++;
        pop = (q.size() != 0) && ev_ready;
        have_ev = 1'b0;
        ev = '0;
        c = m_chan();
        if (c >= 0) begin
            s = b_d2[c];
            if (s == last_s[c]) begin
                if (run[c] < DEPTH) run[c]++;
            end else begin
                run[c] = 1;
                last_s[c] = s;
            end
            if (run[c] == DEPTH && s != m_level[c]) begin
                m_level[c] = s;
                cc = c[1:0];
                ev = {cc, s};
                have_ev = 1'b1;
            end
        end
        if (pop) m_last = q.pop_front();
        drop = have_ev && (q.size() >= FD);
        if (have_ev && !drop) q.push_back(ev);
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        b_d2 = b_d1;
        b_d1 = btn_in;
        k++;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called one delta after a rising edge; resets asynchronously mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_level", level_out, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_head", {ev_ch, ev_level}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        n_pop = 0;
    endtask

    initial begin
        int hold [N_CH];
        int base;

        @(posedge clk);
        #1;

        // 1: ch2 held high from reset release
        btn_in = 4'b0100;
        ev_ready = 1'b1;
        do_reset();
        steps(30 * P);
        chk("t1_events", n_pop, 1);
        chk("t1_level", level_out, 4'b0100);

        // 2: ch0 bouncing every 20 clocks must never settle
        base = n_pop;
        for (int i = 0; i < 20; i++) begin
            btn_in[0] = ~btn_in[0];
            steps(20);
        end
        btn_in[0] = 1'b0;
        steps(10 * P);
        chk("t2_events", n_pop - base, 0);
        chk("t2_level0", level_out[0], 0);

        // 3: press then release ch1
        btn_in = '0;
        do_reset();
        btn_in = 4'b0010;
        steps(10 * P);
        chk("t3_press_level", level_out, 4'b0010);
        btn_in = '0;
        steps(10 * P);
        chk("t3_events", n_pop, 2);
        chk("t3_level1", level_out[1], 0);

        // 4: consumer stalled, press and release all; releases are dropped
        ev_ready = 1'b0;
        do_reset();
        btn_in = 4'b1111;
        steps(10 * P);
        btn_in = 4'b0000;
        steps(10 * P);
        chk("t4_ovf", overflow, 1);
        chk("t4_level", level_out, 0);
        chk("t4_valid", ev_valid, 1);
        ev_ready = 1'b1;
        steps(10);
        chk("t4_drained", n_pop, 4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        step();
        chk("t4_ovf_clr", overflow, 0);

        // 5: full FIFO, pop exactly in each push cycle
        ev_ready = 1'b0;
        do_reset();
        btn_in = 4'b1111;
        steps(10 * P);
        chk("t5_full_valid", ev_valid, 1);
        btn_in = 4'b0001;
        for (int i = 0; i < 12 * P; i++) begin
            ev_ready = push_now();
            step();
        end
        ev_ready = 1'b0;
        chk("t5_pops", n_pop, 3);
        chk("t5_ovf", overflow, 0);
        chk("t5_level", level_out, 4'b0001);
        ev_ready = 1'b1;
        steps(10);
        chk("t5_count", n_pop, 7);

        // 6: reset in the middle of a scan with all levels high
        do_reset();
        btn_in = 4'b1111;
        steps(10 * P);
        for (int i = 0; i < P; i++) begin
            if ((k % P) == 2) break;
            step();
        end
        chk("t6_pre_level", level_out, 4'b1111);
        chk("t6_phase", k % P, 2);
        do_reset();
        steps(DEPTH * P);
        chk("t6_early", n_pop, 0);
        steps(2 * P);
        chk("t6_events", n_pop, 4);
        chk("t6_level", level_out, 4'b1111);

        // Random phase: random hold times per channel, bursty consumer
        do_reset();
        btn_in = '0;
        for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 250);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    btn_in[c] = ~btn_in[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20)
                                                          : $urandom_range(100, 300);
                end
            end
            if ($urandom_range(0, 31) == 0) ev_ready = ~ev_ready;
            clr_ovf = ($urandom_range(0, 99) == 0);
            step();
        end
        clr_ovf = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
